// File: rtl/crotchet_if.sv
// Control and status bundle for crotchet_sequencer: the controller drives
// start/stop/pause (master) and the sequencer drives position and status (slave).
interface crotchet_if;
    logic       start;
    logic       stop;
    logic       pause;
    logic [6:0] crotchet;
    logic       crotchet_pulse;
    logic [3:0] phrase;
    logic       running;
    logic       done;

    modport master (
        output start, stop, pause,
        input  crotchet, crotchet_pulse, phrase, running, done
    );

    modport slave (
        input  start, stop, pause,
        output crotchet, crotchet_pulse, phrase, running, done
    );
endinterface

// File: rtl/crotchet_sequencer.sv
// Tempo-driven crotchet sequencer: steps an index every CYCLES_PER_CROTCHET clocks.
// Define SEQ_LOOP_EN to wrap at the end of the sequence instead of stopping in DONE.
module crotchet_sequencer #(
    parameter int unsigned CYCLES_PER_CROTCHET = 12587500,
    parameter int unsigned NUM_CROTCHETS       = 104
) (
    input logic       clk,
    input logic       rst_n,
    crotchet_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED
`ifndef SEQ_LOOP_EN
        , S_DONE
`endif
    } state_t;

    localparam logic [23:0] TC_VAL = 24'(CYCLES_PER_CROTCHET - 1);
    localparam logic [6:0]  LAST   = 7'(NUM_CROTCHETS - 1);

    state_t      state_q;
    logic [23:0] cnt_q, cnt_d;
    logic [6:0]  crotchet_q, crotchet_d;
    logic        pulse_q, running_q, done_q;
    logic        tc, last;

    assign cnt_d      = cnt_q + 24'd1;
    assign crotchet_d = crotchet_q + 7'd1;
    assign tc         = (cnt_q == TC_VAL);
    assign last       = (crotchet_q == LAST);

    // PAUSED with pause low counts exactly like RUN, so a pause of N cycles
    // delays the next pulse by exactly N cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            crotchet_q <= '0;
            pulse_q    <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.stop) begin
                state_q    <= S_IDLE;
                cnt_q      <= '0;
                crotchet_q <= '0;
                running_q  <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_RUN, S_PAUSED: begin
                        if (bus.pause) begin
                            state_q <= S_PAUSED;
                        end else if (tc) begin
                            cnt_q <= '0;
                            if (last) begin
`ifdef SEQ_LOOP_EN
                                state_q    <= S_RUN;
                                crotchet_q <= '0;
                                pulse_q    <= 1'b1;
`else
                                state_q    <= S_DONE;
                                running_q  <= 1'b0;
                                done_q     <= 1'b1;
`endif
                            end else begin
                                state_q    <= S_RUN;
                                crotchet_q <= crotchet_d;
                                pulse_q    <= 1'b1;
                            end
                        end else begin
                            state_q <= S_RUN;
                            cnt_q   <= cnt_d;
                        end
                    end
                    default: begin
                        // IDLE, and DONE when present: start restarts from crotchet 0
                        if (bus.start) begin
                            state_q    <= S_RUN;
                            cnt_q      <= '0;
                            crotchet_q <= '0;
                            pulse_q    <= 1'b1;
                            running_q  <= 1'b1;
                            done_q     <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.crotchet       = crotchet_q;
    assign bus.crotchet_pulse = pulse_q;
    assign bus.phrase         = crotchet_q[6:3];
    assign bus.running        = running_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_crotchet_sequencer.sv
// Directed bench for crotchet_sequencer at 4 cycles/crotchet, 16 crotchets.
// Build with SEQ_LOOP_EN defined to exercise the wrapping variant.
module tb_crotchet_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   p_cyc;
    logic prev_pulse = 1'b0;

    crotchet_if bus ();

    crotchet_sequencer #(
        .CYCLES_PER_CROTCHET(4),
        .NUM_CROTCHETS      (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1ns later and check the pulse invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.crotchet_pulse) begin
            chk("pulse_dbl", {31'd0, prev_pulse}, 0);
            chk("pulse_run", {31'd0, bus.running}, 1);
        end
        prev_pulse = bus.crotchet_pulse;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_crotchet(input string tag, input int idx);
        int found;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (bus.crotchet_pulse && bus.crotchet == 7'(idx)) found = 1;
        end
        chk(tag, found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        ticks(2);
        chk("rst_crotchet", bus.crotchet, 0);
        chk("rst_pulse", bus.crotchet_pulse, 0);
        chk("rst_phrase", bus.phrase, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;
        ticks(7);

        // Basic run: pulse right after start, then every 4 cycles
        do_start();
        chk("run_p0", bus.crotchet_pulse, 1);
        chk("run_c0", bus.crotchet, 0);
        chk("run_running", bus.running, 1);
        for (int k = 1; k <= 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                chk("run_pulse", bus.crotchet_pulse, (j == 3) ? 1 : 0);
            end
            chk("run_crotchet", bus.crotchet, k);
            chk("run_phrase", bus.phrase, 0);
        end

        // Pause for 10 cycles starting 2 cycles after the crotchet-3 pulse
        p_cyc = cyc;
        ticks(1);
        bus.pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pause_nopulse", bus.crotchet_pulse, 0);
        end
        chk("pause_running", bus.running, 1);
        chk("pause_hold", bus.crotchet, 3);
        bus.pause = 1'b0;
        for (int i = 0; i < 20 && !bus.crotchet_pulse; i++) tick();
        chk("pause_gap", cyc - p_cyc, 14);
        chk("pause_c4", bus.crotchet, 4);

        // Terminal behaviour
        wait_crotchet("wait_c15", 15);
        chk("term_phrase1", bus.phrase, 1);
        ticks(4);
`ifdef SEQ_LOOP_EN
        chk("loop_pulse", bus.crotchet_pulse, 1);
        chk("loop_c0", bus.crotchet, 0);
        chk("loop_phrase0", bus.phrase, 0);
        chk("loop_done", bus.done, 0);
        chk("loop_running", bus.running, 1);
        do_start();
        chk("loop_start_ign_p", bus.crotchet_pulse, 0);
        chk("loop_start_ign_r", bus.running, 1);
`else
        chk("term_pulse", bus.crotchet_pulse, 0);
        chk("term_done", bus.done, 1);
        chk("term_running", bus.running, 0);
        chk("term_c15", bus.crotchet, 15);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("term_nopulse", bus.crotchet_pulse, 0);
        end
        chk("term_done_hold", bus.done, 1);
        do_start();
        chk("restart_pulse", bus.crotchet_pulse, 1);
        chk("restart_c0", bus.crotchet, 0);
        chk("restart_running", bus.running, 1);
        chk("restart_done", bus.done, 0);
`endif
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stop_running", bus.running, 0);
        chk("stop_c0", bus.crotchet, 0);
        chk("stop_done", bus.done, 0);

        // start and stop together in IDLE
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("ss_pulse", bus.crotchet_pulse, 0);
        chk("ss_running", bus.running, 0);
        tick();
        chk("ss_pulse2", bus.crotchet_pulse, 0);

        // stop while PAUSED
        do_start();
        ticks(4);
        chk("sp_c1", bus.crotchet, 1);
        bus.pause = 1'b1;
        ticks(2);
        bus.stop = 1'b1;
        tick();
        bus.stop  = 1'b0;
        bus.pause = 1'b0;
        chk("sp_running", bus.running, 0);
        chk("sp_c0", bus.crotchet, 0);
        chk("sp_pulse", bus.crotchet_pulse, 0);

        // stop on the terminal-count cycle
        do_start();
        ticks(3);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("stc_pulse", bus.crotchet_pulse, 0);
        chk("stc_c0", bus.crotchet, 0);
        chk("stc_running", bus.running, 0);

        // Reset mid-run at crotchet 9
        do_start();
        wait_crotchet("wait_c9", 9);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_crotchet", bus.crotchet, 0);
        chk("mr_pulse", bus.crotchet_pulse, 0);
        chk("mr_phrase", bus.phrase, 0);
        chk("mr_running", bus.running, 0);
        chk("mr_done", bus.done, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mr_nopulse", bus.crotchet_pulse, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/crotchet_sequencer.md
CROTCHET_SEQUENCER -- requirements
Module: crotchet_sequencer

Interface
REQ-001 The block SHALL have parameter CYCLES_PER_CROTCHET, default 12587500, meaning clk cycles per crotchet (legal range 2..2^24).
REQ-002 The block SHALL have parameter NUM_CROTCHETS, default 104, meaning sequence length (13 phrases x 8; legal range 2..128).
REQ-003 Port clk SHALL be input, width 1: the system clock.
REQ-004 Port rst_n SHALL be input, width 1: reset, synchronous, active-low; clock clk.
REQ-005 Port start SHALL be input, width 1: a one-cycle request to begin the sequence from crotchet 0.
REQ-006 Port stop SHALL be input, width 1: a one-cycle request to abort to idle.
REQ-007 Port pause SHALL be input, width 1: a level; while high, tempo counting freezes.
REQ-008 Port crotchet SHALL be output, width 7: the current crotchet index.
REQ-009 Port crotchet_pulse SHALL be output, width 1: a one-cycle strobe marking entry to a new crotchet.
REQ-010 Port phrase SHALL be output, width 4: crotchet[6:3].
REQ-011 Port running SHALL be output, width 1: high in states RUN and PAUSED.
REQ-012 Port done SHALL be output, width 1: high in state DONE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSED and DONE, with a 24-bit tempo counter cnt and a registered crotchet index.
REQ-014 In IDLE, start SHALL go to RUN with crotchet=0 and cnt=0, and SHALL assert crotchet_pulse in the cycle after start.
REQ-015 In RUN with pause low, cnt SHALL increment each cycle.
REQ-016 In RUN, at cnt==CYCLES_PER_CROTCHET-1, cnt SHALL return to 0 and crotchet SHALL advance by 1, with crotchet_pulse high in the first cycle the new index is visible.
REQ-017 Successive pulses in RUN SHALL be exactly CYCLES_PER_CROTCHET cycles apart.
REQ-018 In RUN, pause high SHALL go to PAUSED; cnt and crotchet SHALL hold and no pulse SHALL be issued.
REQ-019 In PAUSED, pause low SHALL return to RUN, resuming from the held cnt; no extra pulse SHALL be issued.
REQ-020 If pause and terminal count occur in the same cycle, pause SHALL win: no advance and no pulse.
REQ-021 Terminal behaviour at crotchet==NUM_CROTCHETS-1 and terminal count SHALL follow REQ-029 and REQ-030.
REQ-022 stop in any state SHALL go to IDLE with crotchet=0, cnt=0, done=0, and no pulse; stop SHALL take priority over start, pause and terminal count.
REQ-023 start SHALL be ignored in RUN and PAUSED.
REQ-024 start in DONE SHALL restart exactly as from IDLE (REQ-014).
REQ-025 crotchet_pulse SHALL never be high for two consecutive cycles, and SHALL never be high outside RUN.

Reset
REQ-026 While rst_n is low at a clk edge, the block SHALL enter IDLE with cnt=0, crotchet=0, crotchet_pulse=0, phrase=0, running=0 and done=0.
REQ-027 Reset asserted mid-sequence SHALL abort immediately, with no pulse in the reset cycle or the following cycle.
REQ-028 All outputs SHALL be registered.

Configuration
REQ-029 With SEQ_LOOP_EN defined, the last crotchet reaching terminal count SHALL wrap crotchet to 0, pulse, and remain in RUN; done SHALL never assert.
REQ-030 Without SEQ_LOOP_EN, the last crotchet reaching terminal count SHALL go to DONE with crotchet held at NUM_CROTCHETS-1, no pulse and done=1; the DONE state SHALL be removed from the design when SEQ_LOOP_EN is defined.

Verification (CYCLES_PER_CROTCHET=4, NUM_CROTCHETS=16)
REQ-031 Run: rst_n low 2 cycles, then start at cycle 10 -> pulse at 11 with crotchet=0, then pulses at 15, 19, 23 with crotchet 1, 2, 3; phrase=0.
REQ-032 Pause: pause high for 10 cycles starting 2 cycles after a pulse -> no pulse during the pause, and the next pulse arrives 14 cycles after the prior pulse.
REQ-033 Terminal without SEQ_LOOP_EN: after 16 pulses, done=1, running=0, crotchet=15, no further pulses; then start -> pulse with crotchet=0 and running=1.
REQ-034 Terminal with SEQ_LOOP_EN: the pulse after crotchet=15 carries crotchet=0; done stays 0; phrase goes 1 -> 0.
REQ-035 Priority: start and stop in the same cycle in IDLE -> stays IDLE, no pulse; stop in PAUSED -> IDLE, crotchet=0; stop coinciding with terminal count -> no pulse.
REQ-036 Reset at crotchet=9 mid-RUN -> all outputs 0 the next cycle, no pulse for the following 8 cycles.
